// File: rtl/tile_pkg.sv
// Shared types and default widths for the tile descriptor path and the input-window fetcher.
package tile_pkg;

  localparam int unsigned DIM_W_DEF  = 16;
  localparam int unsigned ADDR_W_DEF = 24;

  // Window descriptor as produced by the tile controller.
  typedef struct packed {
    logic signed [DIM_W_DEF:0] in_row;
    logic signed [DIM_W_DEF:0] in_col;
    logic [DIM_W_DEF-1:0]      in_h;
    logic [DIM_W_DEF-1:0]      in_w;
  } tile_desc_t;

  typedef struct packed {
    logic signed [DIM_W_DEF:0] row;
    logic signed [DIM_W_DEF:0] col;
    logic                      pad;
    logic [ADDR_W_DEF-1:0]     addr;
    logic                      last;
  } pix_req_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/tile_raster_cnt.sv
// 2-D raster counter: column runs 0..w-1, then wraps and bumps the row.
module tile_raster_cnt #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] h_i,
  input  logic [CNT_W-1:0] w_i,
  output logic [CNT_W-1:0] r_cnt_o,
  output logic [CNT_W-1:0] c_cnt_o,
  output logic             last_c_o
);

  logic [CNT_W-1:0] r_q, r_d;
  logic [CNT_W-1:0] c_q, c_d;
  logic             col_wrap_c;
  logic             row_last_c;

  assign col_wrap_c = (c_q == w_i - CNT_W'(1));
  assign row_last_c = (r_q == h_i - CNT_W'(1));
  assign last_c_o   = col_wrap_c && row_last_c;
  assign r_cnt_o    = r_q;
  assign c_cnt_o    = c_q;

  // Clear has priority over advance.
  always_comb begin
    r_d = r_q;
    c_d = c_q;
    if (clr_i) begin
      r_d = '0;
      c_d = '0;
    end else if (en_i) begin
      if (col_wrap_c) begin
        c_d = '0;
        r_d = r_q + CNT_W'(1);
      end else begin
        c_d = c_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
      c_q <= '0;
    end else begin
      r_q <= r_d;
      c_q <= c_d;
    end
  end

endmodule

// File: rtl/tile_in_fetch.sv
// Accepts one input-window descriptor and walks it in raster order, emitting a
// linear pixel address or a padding flag for each position.
module tile_in_fetch
  import tile_pkg::*;
#(
  parameter int unsigned DIM_W  = DIM_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DIM_W-1:0]        cfg_img_h,
  input  logic [DIM_W-1:0]        cfg_img_w,
  input  logic                    desc_valid,
  output logic                    desc_ready,
  input  logic signed [DIM_W:0]   desc_in_row,
  input  logic signed [DIM_W:0]   desc_in_col,
  input  logic [DIM_W-1:0]        desc_in_h,
  input  logic [DIM_W-1:0]        desc_in_w,
  output logic                    pix_valid,
  input  logic                    pix_ready,
  output logic signed [DIM_W:0]   pix_row,
  output logic signed [DIM_W:0]   pix_col,
  output logic                    pix_pad,
  output logic [ADDR_W-1:0]       pix_addr,
  output logic                    pix_last,
  output logic                    tile_done,
  output logic                    busy
);

  localparam int unsigned CRD_W  = DIM_W + 1;
  localparam int unsigned PROD_W = 2 * DIM_W + 1;

  fetch_state_e            state_q;
  logic                    desc_ready_q;
  logic                    pix_valid_q;
  logic                    tile_done_q;
  logic                    busy_q;
  logic signed [CRD_W-1:0] org_row_q;
  logic signed [CRD_W-1:0] org_col_q;
  logic [DIM_W-1:0]        win_h_q;
  logic [DIM_W-1:0]        win_w_q;
  logic [DIM_W-1:0]        img_h_q;
  logic [DIM_W-1:0]        img_w_q;

  logic [DIM_W-1:0]        r_cnt;
  logic [DIM_W-1:0]        c_cnt;
  logic                    last_c;
  logic                    accept_c;
  logic                    pix_hs_c;
  logic                    zero_size_c;
  logic                    row_out_c;
  logic                    col_out_c;

  assign accept_c    = desc_valid && desc_ready_q;
  assign pix_hs_c    = pix_valid_q && pix_ready;
  assign zero_size_c = (desc_in_h == '0) || (desc_in_w == '0);

  tile_raster_cnt #(
    .CNT_W (DIM_W)
  ) u_raster_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (accept_c),
    .en_i     (pix_hs_c),
    .h_i      (win_h_q),
    .w_i      (win_w_q),
    .r_cnt_o  (r_cnt),
    .c_cnt_o  (c_cnt),
    .last_c_o (last_c)
  );

  // Window sequencing; a zero-area window completes without entering RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      desc_ready_q <= 1'b1;
      pix_valid_q  <= 1'b0;
      tile_done_q  <= 1'b0;
      busy_q       <= 1'b0;
      org_row_q    <= '0;
      org_col_q    <= '0;
      win_h_q      <= '0;
      win_w_q      <= '0;
      img_h_q      <= '0;
      img_w_q      <= '0;
    end else begin
      tile_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept_c) begin
            org_row_q <= desc_in_row;
            org_col_q <= desc_in_col;
            win_h_q   <= desc_in_h;
            win_w_q   <= desc_in_w;
            img_h_q   <= cfg_img_h;
            img_w_q   <= cfg_img_w;
            if (zero_size_c) begin
              tile_done_q <= 1'b1;
            end else begin
              state_q      <= ST_RUN;
              desc_ready_q <= 1'b0;
              pix_valid_q  <= 1'b1;
              busy_q       <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (pix_hs_c && last_c) begin
            state_q      <= ST_IDLE;
            desc_ready_q <= 1'b1;
            pix_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            tile_done_q  <= 1'b1;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          desc_ready_q <= 1'b1;
          pix_valid_q  <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  // Request fields come only from registers, so they hold while stalled.
  assign pix_row   = org_row_q + $signed({1'b0, r_cnt});
  assign pix_col   = org_col_q + $signed({1'b0, c_cnt});
  assign row_out_c = pix_row[DIM_W] || (pix_row >= $signed({1'b0, img_h_q}));
  assign col_out_c = pix_col[DIM_W] || (pix_col >= $signed({1'b0, img_w_q}));
  assign pix_pad   = row_out_c || col_out_c;
  assign pix_addr  = pix_pad ? '0
                   : ADDR_W'(PROD_W'(pix_row[DIM_W-1:0]) * PROD_W'(img_w_q)
                             + PROD_W'(pix_col[DIM_W-1:0]));
  assign pix_last  = last_c;

  assign desc_ready = desc_ready_q;
  assign pix_valid  = pix_valid_q;
  assign tile_done  = tile_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_tile_in_fetch.sv
// Directed bench for tile_in_fetch: padding/address windows, backpressure,
// zero-size, back-to-back descriptors and mid-window reset.
module tb_tile_in_fetch;

  localparam int unsigned DIM_W  = 16;
  localparam int unsigned ADDR_W = 24;
  localparam int unsigned CRD_W  = DIM_W + 1;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [DIM_W-1:0]      cfg_img_h;
  logic [DIM_W-1:0]      cfg_img_w;
  logic                  desc_valid;
  logic                  desc_ready;
  logic signed [DIM_W:0] desc_in_row;
  logic signed [DIM_W:0] desc_in_col;
  logic [DIM_W-1:0]      desc_in_h;
  logic [DIM_W-1:0]      desc_in_w;
  logic                  pix_valid;
  logic                  pix_ready;
  logic signed [DIM_W:0] pix_row;
  logic signed [DIM_W:0] pix_col;
  logic                  pix_pad;
  logic [ADDR_W-1:0]     pix_addr;
  logic                  pix_last;
  logic                  tile_done;
  logic                  busy;

  tile_in_fetch #(.DIM_W(DIM_W), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_img_h   (cfg_img_h),
    .cfg_img_w   (cfg_img_w),
    .desc_valid  (desc_valid),
    .desc_ready  (desc_ready),
    .desc_in_row (desc_in_row),
    .desc_in_col (desc_in_col),
    .desc_in_h   (desc_in_h),
    .desc_in_w   (desc_in_w),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_row     (pix_row),
    .pix_col     (pix_col),
    .pix_pad     (pix_pad),
    .pix_addr    (pix_addr),
    .pix_last    (pix_last),
    .tile_done   (tile_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  logic [63:0] got [16];
  int n_got;

  // Hand-computed windows: 4x4 image at (-1,-1) 3x3, and 5x7 image at (3,5) 3x3.
  int s1_row  [9] = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};
  int s1_col  [9] = '{-1, 0, 1, -1, 0, 1, -1, 0, 1};
  int s1_pad  [9] = '{1, 1, 1, 1, 0, 0, 1, 0, 0};
  int s1_addr [9] = '{0, 0, 0, 0, 0, 1, 0, 4, 5};
  int s2_row  [9] = '{3, 3, 3, 4, 4, 4, 5, 5, 5};
  int s2_col  [9] = '{5, 6, 7, 5, 6, 7, 5, 6, 7};
  int s2_pad  [9] = '{0, 0, 1, 0, 0, 1, 1, 1, 1};
  int s2_addr [9] = '{26, 27, 0, 33, 34, 0, 0, 0, 0};

  function automatic logic [63:0] pack_pix(input int row, input int col, input int pad,
                                           input int addr, input int last);
    return {3'b000, 1'b1, CRD_W'(row), CRD_W'(col), pad[0], ADDR_W'(addr), last[0]};
  endfunction

  function automatic logic [63:0] cur_pix();
    return {3'b000, pix_valid, pix_row, pix_col, pix_pad, pix_addr, pix_last};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    total = total + 1;
    assert (obs === want) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
  endtask

  // Present a descriptor at a negedge; returns at the negedge after accept.
  task automatic send_desc(input int row, input int col, input int h, input int w,
                           input int img_h, input int img_w);
    cfg_img_h   = DIM_W'(img_h);
    cfg_img_w   = DIM_W'(img_w);
    desc_in_row = CRD_W'(row);
    desc_in_col = CRD_W'(col);
    desc_in_h   = DIM_W'(h);
    desc_in_w   = DIM_W'(w);
    desc_valid  = 1'b1;
    check("desc_ready_idle", 64'(desc_ready), 64'd1);
    @(negedge clk);
    desc_valid = 1'b0;
    cfg_img_h  = DIM_W'(1);
    cfg_img_w  = DIM_W'(1);
  endtask

  // mode 0: always ready; mode 1: ready pattern 1,0,0,1 repeating.
  task automatic collect(input int mode);
    logic [63:0] prev;
    logic [63:0] cur;
    bit stall;
    bit done;
    prev  = '0;
    stall = 1'b0;
    done  = 1'b0;
    n_got = 0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      pix_ready = (mode == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
      #1;
      cur = cur_pix();
      if (stall) check("stall_hold", cur, prev);
      if (pix_valid && pix_ready) begin
        if (n_got < 16) got[n_got] = cur;
        n_got = n_got + 1;
        if (pix_last) done = 1'b1;
      end
      stall = pix_valid && !pix_ready;
      prev  = cur;
      @(negedge clk);
    end
    if (!done) check("window_timeout", 64'd0, 64'd1);
    pix_ready = 1'b1;
  endtask

  task automatic verify(input string tag, input int scen);
    logic [63:0] want;
    check({tag, "_count"}, 64'(n_got), 64'd9);
    for (int i = 0; i < 9; i++) begin
      if (scen == 1)
        want = pack_pix(s1_row[i], s1_col[i], s1_pad[i], s1_addr[i], (i == 8) ? 1 : 0);
      else
        want = pack_pix(s2_row[i], s2_col[i], s2_pad[i], s2_addr[i], (i == 8) ? 1 : 0);
      if (i < n_got) check($sformatf("%s_px%0d", tag, i), got[i], want);
    end
  endtask

  task automatic post_window(input string tag);
    check({tag, "_done_pulse"}, 64'(tile_done), 64'd1);
    check({tag, "_idle_valid"}, 64'(pix_valid), 64'd0);
    check({tag, "_idle_ready"}, 64'(desc_ready), 64'd1);
    check({tag, "_idle_busy"}, 64'(busy), 64'd0);
    @(negedge clk);
    check({tag, "_done_clear"}, 64'(tile_done), 64'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    cfg_img_h   = '0;
    cfg_img_w   = '0;
    desc_valid  = 1'b0;
    desc_in_row = '0;
    desc_in_col = '0;
    desc_in_h   = '0;
    desc_in_w   = '0;
    pix_ready   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_desc_ready", 64'(desc_ready), 64'd1);
    check("rst_pix_valid", 64'(pix_valid), 64'd0);
    check("rst_tile_done", 64'(tile_done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Padded window in a 4x4 image.
    pix_ready = 1'b1;
    send_desc(-1, -1, 3, 3, 4, 4);
    check("s1_first_latency", 64'(pix_valid), 64'd1);
    check("s1_busy", 64'(busy), 64'd1);
    check("s1_run_not_ready", 64'(desc_ready), 64'd0);
    collect(0);
    verify("s1", 1);
    post_window("s1");

    // Window straddling the bottom-right edge of a 5x7 image.
    send_desc(3, 5, 3, 3, 5, 7);
    collect(0);
    verify("s2", 2);
    post_window("s2");

    // Same as the first window under backpressure.
    send_desc(-1, -1, 3, 3, 4, 4);
    collect(1);
    verify("s3", 1);
    post_window("s3");

    // Zero-height window.
    send_desc(0, 0, 0, 4, 4, 4);
    check("s4_no_valid", 64'(pix_valid), 64'd0);
    check("s4_done_pulse", 64'(tile_done), 64'd1);
    check("s4_ready", 64'(desc_ready), 64'd1);
    @(negedge clk);
    check("s4_done_clear", 64'(tile_done), 64'd0);
    check("s4_still_no_valid", 64'(pix_valid), 64'd0);

    // Back-to-back: second descriptor held valid through RUN.
    pix_ready   = 1'b1;
    cfg_img_h   = DIM_W'(4);
    cfg_img_w   = DIM_W'(4);
    desc_in_row = CRD_W'(0);
    desc_in_col = CRD_W'(0);
    desc_in_h   = DIM_W'(1);
    desc_in_w   = DIM_W'(2);
    desc_valid  = 1'b1;
    @(negedge clk);
    desc_in_row = CRD_W'(2);
    desc_in_col = CRD_W'(3);
    desc_in_h   = DIM_W'(1);
    desc_in_w   = DIM_W'(1);
    check("s5_run_not_ready", 64'(desc_ready), 64'd0);
    check("s5_a_px0", cur_pix(), pack_pix(0, 0, 0, 0, 0));
    @(negedge clk);
    check("s5_a_px1", cur_pix(), pack_pix(0, 1, 0, 1, 1));
    @(negedge clk);
    check("s5_a_done", 64'(tile_done), 64'd1);
    check("s5_a_ready", 64'(desc_ready), 64'd1);
    check("s5_a_idle", 64'(pix_valid), 64'd0);
    @(negedge clk);
    desc_valid = 1'b0;
    check("s5_b_px0", cur_pix(), pack_pix(2, 3, 0, 11, 1));
    check("s5_b_no_done", 64'(tile_done), 64'd0);
    @(negedge clk);
    post_window("s5_b");

    // Reset after four of nine handshakes.
    pix_ready = 1'b1;
    send_desc(-1, -1, 3, 3, 4, 4);
    repeat (4) @(negedge clk);
    check("s6_pre_rst_px4", cur_pix(), pack_pix(0, 0, 0, 0, 0));
    #2 rst_n = 1'b0;
    #1;
    check("s6_async_valid", 64'(pix_valid), 64'd0);
    check("s6_async_ready", 64'(desc_ready), 64'd1);
    check("s6_async_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("s6_no_done_in_rst", 64'(tile_done), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("s6_no_done_after", 64'(tile_done), 64'd0);
    send_desc(-1, -1, 3, 3, 4, 4);
    check("s6_restart_px0", cur_pix(), pack_pix(-1, -1, 1, 0, 0));
    collect(0);
    verify("s6", 1);
    post_window("s6");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
